// File: rtl/sprite_anim_renderer.sv
// Animated, directional sprite over a per-pixel background. Three-stage fixed-latency
// pixel pipeline in front of an external synchronous sprite ROM and a combinational palette.
module sprite_anim_renderer #(
  parameter int SPR_W       = 28,
  parameter int SPR_H       = 38,
  parameter int SCALE_SHIFT = 0,
  parameter int NUM_DIRS    = 4,
  parameter int NUM_FRAMES  = 2,
  parameter int IDX_W       = 3,
  parameter int TRANSP_IDX  = 0,
  parameter int FRAME_DIV   = 8,
  parameter int ADDR_W      = $clog2(SPR_W * SPR_H * NUM_FRAMES * NUM_DIRS),
  parameter int DIR_W       = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [DIR_W-1:0]  dir,
  input  logic              moving,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_idx,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_hit
);

  localparam int FRM_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int TICK_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [9:0] SCR_W = 10'(SPR_W << SCALE_SHIFT);
  localparam logic [9:0] SCR_H = 10'(SPR_H << SCALE_SHIFT);

  logic [9:0]        s_pos_x_q, s_pos_y_q;
  logic [DIR_W-1:0]  s_dir_q;
  logic              s_moving_q;
  logic [TICK_W-1:0] tick_q;
  logic [FRM_W-1:0]  frame_q;

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit1_q, blank1_q, hit2_q, blank2_q;
  logic [11:0]       bg1_q, bg2_q;
  logic [3:0]        red_q, green_q, blue_q, red_d, green_d, blue_d;
  logic              sprite_hit_q, sprite_hit_d;

  logic [10:0]       dx_s, dy_s;
  logic              hit1_s;
  logic [9:0]        lx_s, ly_s;
  logic [FRM_W-1:0]  frame_eff_s;

  // Shadow registers and animation counters update only on the frame pulse.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      s_pos_x_q  <= 10'd0;
      s_pos_y_q  <= 10'd0;
      s_dir_q    <= '0;
      s_moving_q <= 1'b0;
      tick_q     <= '0;
      frame_q    <= '0;
    end else if (frame_start) begin
      s_pos_x_q  <= pos_x;
      s_pos_y_q  <= pos_y;
      s_dir_q    <= dir;
      s_moving_q <= moving;
      if (!moving) begin
        tick_q  <= '0;
        frame_q <= '0;
      end else if (tick_q == TICK_W'(FRAME_DIV - 1)) begin
        tick_q  <= '0;
        frame_q <= (frame_q == FRM_W'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
      end else begin
        tick_q  <= tick_q + 1'b1;
      end
    end
  end

  // Stage 1 combinational: offset, bounds test and texel address.
  always_comb begin
    dx_s        = {1'b0, DrawX} - {1'b0, s_pos_x_q};
    dy_s        = {1'b0, DrawY} - {1'b0, s_pos_y_q};
    hit1_s      = !dx_s[10] && !dy_s[10] && (dx_s[9:0] < SCR_W) && (dy_s[9:0] < SCR_H);
    lx_s        = dx_s[9:0] >> SCALE_SHIFT;
    ly_s        = dy_s[9:0] >> SCALE_SHIFT;
    frame_eff_s = s_moving_q ? frame_q : '0;
    if (hit1_s) begin
      rom_addr_d = ((ADDR_W'(s_dir_q) * ADDR_W'(NUM_FRAMES) + ADDR_W'(frame_eff_s))
                    * ADDR_W'(SPR_H) + ADDR_W'(ly_s)) * ADDR_W'(SPR_W) + ADDR_W'(lx_s);
    end else begin
      rom_addr_d = '0;
    end
  end

  // Stages 1 and 2: address register plus hit/blank/background delay line.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rom_addr_q <= '0;
      hit1_q     <= 1'b0;
      blank1_q   <= 1'b0;
      bg1_q      <= 12'd0;
      hit2_q     <= 1'b0;
      blank2_q   <= 1'b0;
      bg2_q      <= 12'd0;
    end else begin
      rom_addr_q <= rom_addr_d;
      hit1_q     <= hit1_s;
      blank1_q   <= blank;
      bg1_q      <= {bg_red, bg_green, bg_blue};
      hit2_q     <= hit1_q;
      blank2_q   <= blank1_q;
      bg2_q      <= bg1_q;
    end
  end

  // The ROM output is already registered, so it feeds the palette directly to hold 3-cycle latency.
  assign pal_idx = hit2_q ? rom_q : '0;

  // Stage 3 colour select.
  always_comb begin
    red_d        = 4'd0;
    green_d      = 4'd0;
    blue_d       = 4'd0;
    sprite_hit_d = 1'b0;
    if (!blank2_q) begin
      red_d        = 4'd0;
      green_d      = 4'd0;
      blue_d       = 4'd0;
      sprite_hit_d = 1'b0;
    end else if (hit2_q && (rom_q != IDX_W'(TRANSP_IDX))) begin
      red_d        = pal_red;
      green_d      = pal_green;
      blue_d       = pal_blue;
      sprite_hit_d = 1'b1;
    end else begin
      red_d        = bg2_q[11:8];
      green_d      = bg2_q[7:4];
      blue_d       = bg2_q[3:0];
      sprite_hit_d = 1'b0;
    end
  end

  // Stage 3 output registers.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      red_q        <= 4'd0;
      green_q      <= 4'd0;
      blue_q       <= 4'd0;
      sprite_hit_q <= 1'b0;
    end else begin
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      sprite_hit_q <= sprite_hit_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;
  assign sprite_hit = sprite_hit_q;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Directed bench for sprite_anim_renderer: one instance at native scale, one at 2x scale,
// with a behavioural synchronous ROM and a simple combinational palette.
module tb_sprite_anim_renderer;

  logic        vga_clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic        blank, frame_start, moving;
  logic [1:0]  dir;
  logic [3:0]  bg_red, bg_green, bg_blue;
  logic [2:0]  rom_q, rom_val;
  logic [13:0] rom_addr1, rom_addr2;
  logic [2:0]  pal_idx1, pal_idx2;
  logic [3:0]  red1, green1, blue1, red2, green2, blue2;
  logic        hit1, hit2;

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  // Bench ROM: registered output, content chosen per test through rom_val.
  always @(posedge vga_clk) rom_q <= rom_val;

  function automatic logic [3:0] pr(input logic [2:0] i); return {1'b1, i}; endfunction
  function automatic logic [3:0] pg(input logic [2:0] i); return {i, 1'b1}; endfunction
  function automatic logic [3:0] pb(input logic [2:0] i); return {1'b0, ~i}; endfunction

  sprite_anim_renderer dut1 (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moving(moving),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_addr(rom_addr1), .rom_q(rom_q), .pal_idx(pal_idx1),
    .pal_red(pr(pal_idx1)), .pal_green(pg(pal_idx1)), .pal_blue(pb(pal_idx1)),
    .red(red1), .green(green1), .blue(blue1), .sprite_hit(hit1)
  );

  sprite_anim_renderer #(.SCALE_SHIFT(1)) dut2 (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moving(moving),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_addr(rom_addr2), .rom_q(rom_q), .pal_idx(pal_idx2),
    .pal_red(pr(pal_idx2)), .pal_green(pg(pal_idx2)), .pal_blue(pb(pal_idx2)),
    .red(red2), .green(green2), .blue(blue2), .sprite_hit(hit2)
  );

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        bl;
    logic [2:0]  rv;
    logic [11:0] bg;
    logic [13:0] ea;
    logic        eh;
    logic [11:0] ergb;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_px();
    DrawX = 10'd700;
    DrawY = 10'd500;
    blank = 1'b0;
  endtask

  task automatic pulse(input logic [9:0] px, input logic [9:0] py, input logic [1:0] d, input logic mv);
    idle_px();
    pos_x = px; pos_y = py; dir = d; moving = mv;
    frame_start = 1'b1;
    @(posedge vga_clk); #1;
    frame_start = 1'b0;
  endtask

  // Present one pixel, check the address one clock later and the colour three clocks later.
  task automatic run_px(input string nm, input logic [9:0] x, input logic [9:0] y, input logic bl,
                        input logic [2:0] rv, input logic [11:0] bg, input logic [13:0] ea,
                        input logic eh, input logic [11:0] ergb);
    DrawX = x; DrawY = y; blank = bl; rom_val = rv;
    {bg_red, bg_green, bg_blue} = bg;
    @(posedge vga_clk); #1;
    chk({nm, "_addr"}, 32'(rom_addr1), 32'(ea));
    idle_px();
    @(posedge vga_clk);
    @(posedge vga_clk); #1;
    chk({nm, "_rgb"}, 32'({red1, green1, blue1}), 32'(ergb));
    chk({nm, "_hit"}, 32'(hit1), 32'(eh));
  endtask

  task automatic run2(input string nm, input logic [9:0] x, input logic [9:0] y,
                      input logic [13:0] ea, input logic eh);
    DrawX = x; DrawY = y; blank = 1'b1; rom_val = 3'd5;
    @(posedge vga_clk); #1;
    chk({nm, "_addr2"}, 32'(rom_addr2), 32'(ea));
    idle_px();
    @(posedge vga_clk);
    @(posedge vga_clk); #1;
    chk({nm, "_hit2"}, 32'(hit2), 32'(eh));
  endtask

  task automatic probe(input string nm, input logic [9:0] x, input logic [9:0] y, input logic [13:0] ea);
    DrawX = x; DrawY = y; blank = 1'b0;
    @(posedge vga_clk); #1;
    chk(nm, 32'(rom_addr1), 32'(ea));
  endtask

  initial begin
    vt[0] = '{10'd100, 10'd50, 1'b1, 3'd5, 12'h123, 14'd4256, 1'b1, 12'hDB2};
    vt[1] = '{10'd100, 10'd50, 1'b1, 3'd0, 12'hABC, 14'd4256, 1'b0, 12'hABC};
    vt[2] = '{10'd99,  10'd50, 1'b1, 3'd5, 12'h456, 14'd0,    1'b0, 12'h456};
    vt[3] = '{10'd128, 10'd50, 1'b1, 3'd5, 12'h789, 14'd0,    1'b0, 12'h789};
    vt[4] = '{10'd127, 10'd87, 1'b1, 3'd3, 12'h111, 14'd5319, 1'b1, 12'hB74};
    vt[5] = '{10'd127, 10'd88, 1'b1, 3'd3, 12'h222, 14'd0,    1'b0, 12'h222};
    vt[6] = '{10'd100, 10'd49, 1'b1, 3'd5, 12'h333, 14'd0,    1'b0, 12'h333};
    vt[7] = '{10'd110, 10'd60, 1'b0, 3'd5, 12'h444, 14'd4546, 1'b0, 12'h000};
    vt[8] = '{10'd101, 10'd51, 1'b1, 3'd7, 12'h555, 14'd4285, 1'b1, 12'hFF0};

    // Reset with random inputs, frame_start included.
    Reset = 1'b1;
    rom_val = 3'd0;
    for (int i = 0; i < 5; i++) begin
      DrawX = 10'($urandom_range(0, 639)); DrawY = 10'($urandom_range(0, 479));
      blank = 1'($urandom); frame_start = 1'($urandom);
      pos_x = 10'($urandom); pos_y = 10'($urandom); dir = 2'($urandom); moving = 1'($urandom);
      {bg_red, bg_green, bg_blue} = 12'($urandom);
      rom_val = 3'($urandom);
      @(posedge vga_clk); #1;
      chk("rst_rgb", 32'({red1, green1, blue1}), 32'd0);
      chk("rst_hit", 32'(hit1), 32'd0);
      chk("rst_addr", 32'(rom_addr1), 32'd0);
      chk("rst_addr2", 32'(rom_addr2), 32'd0);
    end
    Reset = 1'b0;
    frame_start = 1'b0;
    idle_px();
    {bg_red, bg_green, bg_blue} = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge vga_clk); #1;
      chk("post_rst_rgb", 32'({red1, green1, blue1}), 32'd0);
      chk("post_rst_hit", 32'(hit1), 32'd0);
    end

    // Basic draw, transparency and bounds at pos (100,50), dir 2, still.
    pulse(10'd100, 10'd50, 2'd2, 1'b0);
    for (int i = 0; i < 9; i++) begin
      run_px($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].bl, vt[i].rv,
             vt[i].bg, vt[i].ea, vt[i].eh, vt[i].ergb);
    end

    // Mid-frame position change is ignored until the next frame pulse.
    pos_x = 10'd200;
    run_px("midframe", 10'd100, 10'd50, 1'b1, 3'd5, 12'h123, 14'd4256, 1'b1, 12'hDB2);
    pulse(10'd200, 10'd50, 2'd2, 1'b0);
    run_px("newpos_old", 10'd100, 10'd50, 1'b1, 3'd5, 12'h123, 14'd0, 1'b0, 12'h123);
    run_px("newpos_new", 10'd200, 10'd50, 1'b1, 3'd5, 12'h123, 14'd4256, 1'b1, 12'hDB2);

    // Animation: frame advances every 8 pulses while moving.
    for (int i = 1; i <= 24; i++) begin
      pulse(10'd0, 10'd0, 2'd0, 1'b1);
      probe($sformatf("anim%0d", i), 10'd1, 10'd0, 14'(((i / 8) % 2) * 1064 + 1));
    end
    pulse(10'd0, 10'd0, 2'd0, 1'b0);
    probe("anim_stop", 10'd1, 10'd0, 14'd1);
    for (int i = 1; i <= 8; i++) begin
      pulse(10'd0, 10'd0, 2'd0, 1'b1);
      probe($sformatf("anim_re%0d", i), 10'd1, 10'd0, (i == 8) ? 14'd1065 : 14'd1);
    end
    pulse(10'd0, 10'd0, 2'd0, 1'b0);

    // Scale 2x instance.
    run2("s2_00", 10'd0, 10'd0, 14'd0, 1'b1);
    run2("s2_11", 10'd1, 10'd1, 14'd0, 1'b1);
    run2("s2_22", 10'd2, 10'd2, 14'd29, 1'b1);
    run2("s2_5575", 10'd55, 10'd75, 14'd1063, 1'b1);
    run2("s2_560", 10'd56, 10'd0, 14'd0, 1'b0);
    run2("s2_076", 10'd0, 10'd76, 14'd0, 1'b0);

    // Clipping at the bottom-right corner, no wrap, blanked pixel is black.
    pulse(10'd620, 10'd470, 2'd0, 1'b0);
    run_px("clip_edge", 10'd639, 10'd479, 1'b1, 3'd5, 12'h0F0, 14'd271, 1'b1, 12'hDB2);
    run_px("clip_wrap", 10'd0, 10'd0, 1'b1, 3'd5, 12'h0F0, 14'd0, 1'b0, 12'h0F0);
    run_px("clip_wrap5", 10'd5, 10'd5, 1'b1, 3'd5, 12'h0F0, 14'd0, 1'b0, 12'h0F0);
    run_px("clip_left", 10'd619, 10'd470, 1'b1, 3'd5, 12'h0F0, 14'd0, 1'b0, 12'h0F0);
    run_px("clip_blank", 10'd630, 10'd475, 1'b0, 3'd5, 12'h0F0, 14'd150, 1'b0, 12'h000);

    // Reset wins over a simultaneous frame pulse.
    pos_x = 10'd300; pos_y = 10'd300; dir = 2'd3; moving = 1'b1;
    frame_start = 1'b1; Reset = 1'b1;
    @(posedge vga_clk); #1;
    frame_start = 1'b0; Reset = 1'b0;
    probe("rst_wins", 10'd1, 10'd0, 14'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
